// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the iterative fixed-point square root.
// Build option: SQRT_ROUND_EN adds a guard iteration and round-half-up of the root.
package sqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Root width for an unsigned Q(in_w/2).(frac_w) result.
    function automatic int root_w(input int in_w, input int frac_w);
        return in_w / 2 + frac_w;
    endfunction

    // Number of recurrence steps; rounding needs one extra guard bit.
    function automatic int iter_count(input int in_w, input int frac_w);
`ifdef SQRT_ROUND_EN
        return root_w(in_w, frac_w) + 1;
`else
        return root_w(in_w, frac_w);
`endif
    endfunction

    // The counter only ever holds iters-1 down to 0.
    function automatic int cnt_w(input int iters);
        return (iters <= 2) ? 1 : $clog2(iters);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root step: brings in two radicand bits
// and decides one root bit. Purely combinational so it can be unrolled later.
module sqrt_step #(
    parameter int W = 12
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_root,
    input  logic [1:0]   i_pair,
    output logic [W+1:0] o_rem,
    output logic [W-1:0] o_root
);

    // Before any step the remainder is below 2^W, so W input bits are enough
    // and the shifted remainder fits W+2 bits without loss.
    logic [W+1:0] w_rem_sh;
    logic [W+1:0] w_trial;
    logic         w_take;
    logic [W:0]   w_root_ext;

    assign w_rem_sh   = {i_rem, i_pair};
    assign w_trial    = {i_root, 2'b01};
    assign w_take     = (w_rem_sh >= w_trial);
    assign w_root_ext = {i_root, w_take};

    always_comb begin
        o_rem  = w_rem_sh;
        o_root = w_root_ext[W-1:0];
        if (w_take) begin
            o_rem = w_rem_sh - w_trial;
        end
    end

endmodule

// File: rtl/sqrt_iter.sv
// Sequential unsigned fixed-point square root, one root bit per clock, with
// valid/ready on both sides. Build option: SQRT_ROUND_EN (round half-up, saturating).
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter  int IN_W   = 8,
    parameter  int FRAC_W = 8,
    localparam int ROOT_W = root_w(IN_W, FRAC_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [IN_W-1:0]   i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ROOT_W-1:0] o_out_root,
    output logic              o_out_exact
);

    localparam int ITERS = iter_count(IN_W, FRAC_W);
    localparam int RAD_W = 2 * ITERS;
    localparam int CNT_W = cnt_w(ITERS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [RAD_W-1:0]  r_rad;
    logic [ITERS+1:0]  r_rem;
    logic [ITERS-1:0]  r_root;
    logic              r_out_valid;
    logic [ROOT_W-1:0] r_out_root;
    logic              r_out_exact;

    logic [RAD_W-1:0]  w_rad_load;
    logic [ITERS+1:0]  w_rem_next;
    logic [ITERS-1:0]  w_root_next;
    logic [ROOT_W-1:0] w_fin_root;
    logic              w_fin_exact;

    // Radicand is left-aligned so the fractional (and guard) pairs shift in as zeros.
    assign w_rad_load = RAD_W'(i_in_data) << (RAD_W - IN_W);

    sqrt_step #(
        .W (ITERS)
    ) u_step (
        .i_rem  (r_rem[ITERS-1:0]),
        .i_root (r_root),
        .i_pair (r_rad[RAD_W-1 -: 2]),
        .o_rem  (w_rem_next),
        .o_root (w_root_next)
    );

`ifdef SQRT_ROUND_EN
    logic              w_guard;
    logic [ROOT_W-1:0] w_trunc;
    logic [ROOT_W:0]   w_sum;

    assign w_guard     = r_root[0];
    assign w_trunc     = r_root[ITERS-1:1];
    assign w_sum       = {1'b0, w_trunc} + {{ROOT_W{1'b0}}, w_guard};
    // A carry out means the truncated root was all ones: clamp instead of wrapping.
    assign w_fin_root  = w_sum[ROOT_W] ? {ROOT_W{1'b1}} : w_sum[ROOT_W-1:0];
    assign w_fin_exact = (r_rem == '0) && !w_guard;
`else
    assign w_fin_root  = r_root;
    assign w_fin_exact = (r_rem == '0);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (i_in_valid)                 w_state_next = ST_BUSY;
            ST_BUSY: if (r_cnt == '0)                w_state_next = ST_DONE;
            ST_DONE: if (r_out_valid && i_out_ready) w_state_next = ST_IDLE;
            default:                                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_rad       <= '0;
            r_rem       <= '0;
            r_root      <= '0;
            r_out_valid <= 1'b0;
            r_out_root  <= '0;
            r_out_exact <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_rad  <= w_rad_load;
                        r_rem  <= '0;
                        r_root <= '0;
                        r_cnt  <= CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // First DONE cycle latches the finished result; it then holds until taken.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_root  <= w_fin_root;
                        r_out_exact <= w_fin_exact;
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_root  = r_out_root;
    assign o_out_exact = r_out_exact;

endmodule

// File: tb/tb_sqrt_iter.sv
// Randomised and directed check of sqrt_iter against an integer square-root
// model; instance 0 is IN_W=8/FRAC_W=8, instance 1 is IN_W=8/FRAC_W=0.
module tb_sqrt_iter;

    localparam int IN_W = 8;
    localparam int FR0  = 8;
    localparam int FR1  = 0;
    localparam int RW0  = IN_W / 2 + FR0;
    localparam int RW1  = IN_W / 2 + FR1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid  [2];
    logic [IN_W-1:0] in_data   [2];
    logic            out_ready [2];
    logic            in_ready  [2];
    logic            out_valid [2];
    logic            out_exact [2];
    logic [RW0-1:0]  root0;
    logic [RW1-1:0]  root1;

    int n_total = 0;
    int n_bad   = 0;
    longint last_root;
    bit     last_exact;

    always #5 clk = ~clk;

    sqrt_iter #(.IN_W(IN_W), .FRAC_W(FR0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]), .i_in_data(in_data[0]),
        .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]),
        .o_out_root(root0), .o_out_exact(out_exact[0])
    );

    sqrt_iter #(.IN_W(IN_W), .FRAC_W(FR1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]), .i_in_data(in_data[1]),
        .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]),
        .o_out_root(root1), .o_out_exact(out_exact[1])
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint get_root(input int sel);
        return (sel == 0) ? longint'(root0) : longint'(root1);
    endfunction

    function automatic int frac_of(input int sel);
        return (sel == 0) ? FR0 : FR1;
    endfunction

    function automatic int iters_of(input int sel);
        int rw;
        rw = IN_W / 2 + frac_of(sel);
`ifdef SQRT_ROUND_EN
        return rw + 1;
`else
        return rw;
`endif
    endfunction

    function automatic longint isqrt(input longint n);
        longint lo, hi, mid;
        hi = 1;
        while (hi * hi <= n) hi = hi << 1;
        lo = hi >> 1;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid; else hi = mid;
        end
        return (n == 0) ? 0 : lo;
    endfunction

    // Reference: root of x scaled by 2^(2*frac); rounded form uses one more bit of root.
    task automatic ref_model(input int sel, input int x, output longint root, output bit exact);
        longint n, g, max_root;
        n = longint'(x) << (2 * frac_of(sel));
        max_root = (longint'(1) << (IN_W / 2 + frac_of(sel))) - 1;
`ifdef SQRT_ROUND_EN
        g = isqrt(4 * n);
        root = (g + 1) >> 1;
        if (root > max_root) root = max_root;
        exact = (g * g == 4 * n);
`else
        g = isqrt(n);
        root = g;
        exact = (g * g == n);
        if (root > max_root) root = max_root;
`endif
    endtask

    task automatic run_one(input int sel, input int x, input bit hold);
        longint exp_root;
        bit     exp_exact;
        int     n;
        int     lat;
        ref_model(sel, x, exp_root, exp_exact);
        n = 0;
        while (!in_ready[sel] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val($sformatf("in_ready_wait x=%0d", x), longint'(in_ready[sel]), 1);
        in_valid[sel] = 1'b1;
        in_data[sel]  = IN_W'(x);
        out_ready[sel] = !hold;
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[sel] && lat < 200);
        check_val($sformatf("latency s%0d x=%0d", sel, x), lat, iters_of(sel) + 1);
        last_root  = get_root(sel);
        last_exact = out_exact[sel];
        check_val($sformatf("root s%0d x=%0d", sel, x), last_root, exp_root);
        check_val($sformatf("exact s%0d x=%0d", sel, x), longint'(last_exact), longint'(exp_exact));
        if (hold) begin
            in_valid[sel] = 1'b1;
            in_data[sel]  = IN_W'($urandom);
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                check_val($sformatf("hold_root c%0d", i), get_root(sel), exp_root);
                check_val($sformatf("hold_valid c%0d", i), longint'(out_valid[sel]), 1);
                check_val($sformatf("hold_in_ready c%0d", i), longint'(in_ready[sel]), 0);
            end
            in_valid[sel]  = 1'b0;
            out_ready[sel] = 1'b1;
        end
        @(posedge clk); #1;
        check_val($sformatf("post_valid x=%0d", x), longint'(out_valid[sel]), 0);
        check_val($sformatf("post_in_ready x=%0d", x), longint'(in_ready[sel]), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int s = 0; s < 2; s++) begin
            check_val($sformatf("%s_valid s%0d", tag, s), longint'(out_valid[s]), 0);
            check_val($sformatf("%s_in_ready s%0d", tag, s), longint'(in_ready[s]), 1);
            check_val($sformatf("%s_root s%0d", tag, s), get_root(s), 0);
            check_val($sformatf("%s_exact s%0d", tag, s), longint'(out_exact[s]), 0);
        end
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            in_data[s]   = '0;
            out_ready[s] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed points with spec-given results
        run_one(0, 16, 0);  check_val("tp16_root", last_root, 'h400);
                            check_val("tp16_exact", longint'(last_exact), 1);
        run_one(0, 2, 0);   check_val("tp2_root", last_root, 'h16A);
                            check_val("tp2_exact", longint'(last_exact), 0);
        run_one(0, 3, 0);   check_val("tp3_root", last_root, 'h1BB);
        run_one(0, 0, 0);   check_val("tp0_root", last_root, 0);
                            check_val("tp0_exact", longint'(last_exact), 1);
        run_one(0, 255, 0);
`ifdef SQRT_ROUND_EN
        check_val("tp255_root", last_root, 'hFF8);
`else
        check_val("tp255_root", last_root, 'hFF7);
`endif
        run_one(1, 255, 0); check_val("tp255_f0_root", last_root, 'hF);
        run_one(1, 24, 0);
`ifdef SQRT_ROUND_EN
        check_val("tp24_f0_root", last_root, 'h5);
`else
        check_val("tp24_f0_root", last_root, 'h4);
`endif

        // Backpressure with an ignored in_valid during the hold
        run_one(0, 200, 1);

        // Reset in the middle of a computation
        in_valid[0] = 1'b1;
        in_data[0]  = 8'd99;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_one(0, 16, 0);  check_val("after_rst_root", last_root, 'h400);

        // Reset while a result is being held discards it
        in_valid[0]  = 1'b1;
        in_data[0]   = 8'd16;
        out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("held_before_rst", longint'(out_valid[0]), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("done_rst");
        out_ready[0] = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full sweep of every radicand in random order on both instances
        begin
            int perm[256];
            int j, t;
            for (int i = 0; i < 256; i++) perm[i] = i;
            for (int i = 255; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < 256; i++) begin
                run_one(0, perm[i], 0);
                run_one(1, perm[255 - i], 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
